bip_control: RTL and testbench

//  Control unit for the BIP-I processor. Sequences program-memory fetch, decodes the 5-bit

---
 rtl/bip_control.sv | 159 +++++++++++++++
 tb/tb_bip_control.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// BIP-I control unit: fetch / decode / execute sequencer driving PC, data RAM strobes and the
// accumulator datapath selects. Optional single-step mode is enabled with `define BIP_STEP_EN,
// which adds the i_step input and a STEP_WAIT state between instructions.
//
// Program ROM data arrives during EXEC (one cycle after the FETCH read strobe), so EXEC decodes
// the live i_instr bus and captures it into instr_q for use in WB.
module bip_control #(
    parameter int unsigned NB_OPCODE = 5,
    parameter int unsigned NB_ADDR   = 11,
    parameter int unsigned NB_INSTR  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
`ifdef BIP_STEP_EN
    input  logic                i_step,
`endif
    input  logic [NB_INSTR-1:0] i_instr,
    output logic                o_prog_rd,
    output logic [NB_ADDR-1:0]  o_pc,
    output logic [NB_ADDR-1:0]  o_data_addr,
    output logic                o_rd_ram,
    output logic                o_wr_ram,
    output logic [NB_ADDR-1:0]  o_operand,
    output logic [1:0]          o_sel_a,
    output logic                o_sel_b,
    output logic                o_op,
    output logic                o_wr_acc,
    output logic                o_cycle_en,
    output logic                o_halt
);

    localparam logic [NB_OPCODE-1:0] OpHlt  = NB_OPCODE'(0);
    localparam logic [NB_OPCODE-1:0] OpSto  = NB_OPCODE'(1);
    localparam logic [NB_OPCODE-1:0] OpLd   = NB_OPCODE'(2);
    localparam logic [NB_OPCODE-1:0] OpLdi  = NB_OPCODE'(3);
    localparam logic [NB_OPCODE-1:0] OpAdd  = NB_OPCODE'(4);
    localparam logic [NB_OPCODE-1:0] OpAddi = NB_OPCODE'(5);
    localparam logic [NB_OPCODE-1:0] OpSub  = NB_OPCODE'(6);
    localparam logic [NB_OPCODE-1:0] OpSubi = NB_OPCODE'(7);

`ifdef BIP_STEP_EN
    typedef enum logic [2:0] {StIdle, StFetch, StExec, StWb, StHalt, StStepWait} state_e;
    localparam state_e StNext = StStepWait;
`else
    typedef enum logic [2:0] {StIdle, StFetch, StExec, StWb, StHalt} state_e;
    localparam state_e StNext = StFetch;
`endif

    state_e              state_q, state_d;
    logic [NB_ADDR-1:0]  pc_q, pc_d;
    logic [NB_INSTR-1:0] instr_q, instr_d;
    logic                halt_q, halt_d;

    logic [NB_INSTR-1:0]  cur_instr;
    logic [NB_OPCODE-1:0] opcode;
    logic [NB_ADDR-1:0]   pc_inc;

    // Decode source: live ROM bus in EXEC, captured copy afterwards
    always_comb begin
        cur_instr = (state_q == StExec) ? i_instr : instr_q;
        instr_d   = cur_instr;
        opcode    = cur_instr[NB_INSTR-1 -: NB_OPCODE];
        pc_inc    = pc_q + NB_ADDR'(1);
    end

    assign o_pc        = pc_q;
    assign o_halt      = halt_q;
    assign o_data_addr = cur_instr[NB_ADDR-1:0];
    assign o_operand   = cur_instr[NB_ADDR-1:0];

    // State, PC, instruction and halt registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            instr_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            halt_q  <= halt_d;
        end
    end

    // Next-state logic and Moore control strobes
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        halt_d     = halt_q;
        o_prog_rd  = 1'b0;
        o_rd_ram   = 1'b0;
        o_wr_ram   = 1'b0;
        o_sel_a    = 2'b00;
        o_sel_b    = 1'b0;
        o_op       = 1'b0;
        o_wr_acc   = 1'b0;
        o_cycle_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) state_d = StFetch;
            end
            StFetch: begin
                o_prog_rd  = 1'b1;
                o_cycle_en = 1'b1;
                state_d    = StExec;
            end
            StExec: begin
                o_cycle_en = 1'b1;
                pc_d       = pc_inc;
                state_d    = StNext;
                case (opcode)
                    OpHlt: begin
                        pc_d    = pc_q;
                        halt_d  = 1'b1;
                        state_d = StHalt;
                    end
                    OpSto: o_wr_ram = 1'b1;
                    OpLd, OpAdd, OpSub: begin
                        // RAM data lands next cycle; accumulator loads in WB
                        o_rd_ram = 1'b1;
                        pc_d     = pc_q;
                        state_d  = StWb;
                    end
                    OpLdi: begin
                        o_sel_a  = 2'b01;
                        o_wr_acc = 1'b1;
                    end
                    OpAddi, OpSubi: begin
                        o_sel_a  = 2'b10;
                        o_sel_b  = 1'b1;
                        o_op     = (opcode == OpSubi);
                        o_wr_acc = 1'b1;
                    end
                    default: ;
                endcase
            end
            StWb: begin
                o_cycle_en = 1'b1;
                o_wr_acc   = 1'b1;
                pc_d       = pc_inc;
                state_d    = StNext;
                if (opcode != OpLd) begin
                    o_sel_a = 2'b10;
                    o_op    = (opcode == OpSub);
                end
            end
            StHalt: ;
`ifdef BIP_STEP_EN
            StStepWait: begin
                if (i_step) state_d = StFetch;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_bip_control.sv
// Scoreboard bench for bip_control: directed programs push expected strobe events into a queue;
// a negedge monitor pops and compares on every cycle any RAM/accumulator strobe is active.
module tb_bip_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
`ifdef BIP_STEP_EN
    logic        step = 1'b0;
`endif
    logic [15:0] instr;
    logic        prog_rd, rd_ram, wr_ram, sel_b, op, wr_acc, cycle_en, halt;
    logic [10:0] pc, data_addr, operand;
    logic [1:0]  sel_a;

    bip_control dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_start     (start),
`ifdef BIP_STEP_EN
        .i_step      (step),
`endif
        .i_instr     (instr),
        .o_prog_rd   (prog_rd),
        .o_pc        (pc),
        .o_data_addr (data_addr),
        .o_rd_ram    (rd_ram),
        .o_wr_ram    (wr_ram),
        .o_operand   (operand),
        .o_sel_a     (sel_a),
        .o_sel_b     (sel_b),
        .o_op        (op),
        .o_wr_acc    (wr_acc),
        .o_cycle_en  (cycle_en),
        .o_halt      (halt)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: data valid the cycle after the read strobe
    logic [15:0] rom [0:2047];
    logic [15:0] rom_q = 16'h0;
    always @(posedge clk) if (prog_rd) rom_q <= rom[pc];
    assign instr = rom_q;

    int cyc = 0;
    int base = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          rel;
        logic [39:0] vec;
    } ev_t;
    ev_t sb[$];
    ev_t e;

    function automatic logic [15:0] ins(input int opc, input int a);
        return {opc[4:0], a[10:0]};
    endfunction

    task automatic push(input int rel, input logic w, input logic r, input logic acc,
                        input logic [1:0] sa, input logic sbs, input logic o,
                        input logic [10:0] addr, input logic [10:0] p);
        ev_t n;
        n.rel = rel;
        n.vec = {w, r, acc, sa, sbs, o, addr, addr, p};
        sb.push_back(n);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every strobe cycle must match the next expected event
    always @(negedge clk) begin
        if (rst_n && (wr_ram || rd_ram || wr_acc)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: cycle %0d wr=%b rd=%b acc=%b pc=%0d",
                         cyc - base + 1, wr_ram, rd_ram, wr_acc, pc);
            end else begin
                e = sb.pop_front();
                if (e.rel != cyc - base + 1 ||
                    e.vec !== {wr_ram, rd_ram, wr_acc, sel_a, sel_b, op, data_addr, operand, pc})
                begin
                    errors++;
                    $display("FAIL strobe_event: got cycle %0d vec %h expected cycle %0d vec %h",
                             cyc - base + 1,
                             {wr_ram, rd_ram, wr_acc, sel_a, sel_b, op, data_addr, operand, pc},
                             e.rel, e.vec);
                end
            end
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Caller is #1 after a posedge; returns in cycle 1 (FETCH of PC 0)
    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        base = cyc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int en_cnt;
    int halt_rel;
    int nf;
    logic [10:0] exp_pc;

    initial begin
        clear_rom();
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_prog_rd", 32'(prog_rd), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_strobes", 32'({rd_ram, wr_ram, wr_acc}), 32'd0);
        chk("rst_sel_op", 32'({sel_a, sel_b, op}), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_cycle_en", 32'(cycle_en), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // Reset asserted mid-WB of ADD at PC 1
        rom[0] = ins(3, 9);
        rom[1] = ins(4, 4);
        push(2, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 11'd9, 11'd0);
        push(4, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 11'd4, 11'd1);
        start_pulse();
        repeat (4) next_cycle();
        chk("wb_wr_acc", 32'(wr_acc), 32'd1);
        chk("wb_pc", 32'(pc), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_strobes", 32'({prog_rd, rd_ram, wr_ram, wr_acc}), 32'd0);
        chk("abort_sel_op", 32'({sel_a, sel_b, op}), 32'd0);
        chk("abort_pc", 32'(pc), 32'd0);
        chk("abort_idle", 32'({cycle_en, halt}), 32'd0);
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // LDI 5, ADDI 3, STO 7, HLT; i_start pulsed in HALT afterwards
        clear_rom();
        rom[0] = ins(3, 5);
        rom[1] = ins(5, 3);
        rom[2] = ins(1, 7);
        rom[3] = ins(0, 0);
        push(2, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 11'd5, 11'd0);
        push(4, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 11'd3, 11'd1);
        push(6, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 11'd7, 11'd2);
        start_pulse();
        en_cnt = 0;
        halt_rel = 0;
        for (int r = 1; r <= 14; r++) begin
            if (cycle_en) en_cnt++;
            if (halt && halt_rel == 0) halt_rel = r;
            next_cycle();
        end
        chk("p1_cycle_en_count", 32'(en_cnt), 32'd8);
        chk("p1_halt_cycle", 32'(halt_rel), 32'd9);
        chk("p1_pc_frozen", 32'(pc), 32'd3);
        start_pulse();
        repeat (3) next_cycle();
        chk("halt_start_pc", 32'(pc), 32'd3);
        chk("halt_start_state", 32'({halt, cycle_en, prog_rd}), 32'b100);
        chk("p1_sb_empty", 32'(sb.size()), 32'd0);

        // LD 4, SUB 4, HLT with i_start held high throughout
        do_reset();
        clear_rom();
        rom[0] = ins(2, 4);
        rom[1] = ins(6, 4);
        push(2, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 11'd4, 11'd0);
        push(3, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 11'd4, 11'd0);
        push(5, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 11'd4, 11'd1);
        push(6, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 11'd4, 11'd1);
        start_pulse();
        start = 1'b1;
        halt_rel = 0;
        for (int r = 1; r <= 12; r++) begin
            if (halt && halt_rel == 0) halt_rel = r;
            next_cycle();
        end
        start = 1'b0;
        chk("p2_halt_cycle", 32'(halt_rel), 32'd9);
        chk("p2_pc", 32'(pc), 32'd2);
        chk("p2_sb_empty", 32'(sb.size()), 32'd0);

        // All-NOP ROM: PC walks 0..2047 and wraps, no strobes
        do_reset();
        for (int i = 0; i < 2048; i++) rom[i] = ins(31, i);
        start_pulse();
        nf = 0;
        exp_pc = 11'd0;
        for (int i = 0; i < 4300 && nf < 2050; i++) begin
            if (prog_rd) begin
                if (pc !== exp_pc) chk("nop_pc", 32'(pc), 32'(exp_pc));
                exp_pc = exp_pc + 11'd1;
                nf++;
            end
            next_cycle();
        end
        chk("nop_fetch_count", 32'(nf), 32'd2050);
        chk("nop_pc_wrapped", 32'(exp_pc), 32'd2);
        chk("nop_not_halted", 32'(halt), 32'd0);

`ifdef BIP_STEP_EN
        // Single-step: stall after LDI 1 until i_step
        do_reset();
        clear_rom();
        rom[0] = ins(3, 1);
        push(2, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 11'd1, 11'd0);
        start_pulse();
        repeat (6) next_cycle();
        chk("step_wait_cycle_en", 32'(cycle_en), 32'd0);
        chk("step_wait_pc", 32'(pc), 32'd1);
        chk("step_wait_idle", 32'({halt, prog_rd}), 32'd0);
        step = 1'b1;
        next_cycle();
        step = 1'b0;
        chk("step_fetch", 32'(prog_rd), 32'd1);
        repeat (3) next_cycle();
        chk("step_halt", 32'(halt), 32'd1);
        chk("step_sb_empty", 32'(sb.size()), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
